// File: rtl/plug_pkg.sv
// plug_pkg
// Shared definitions for the programmable Enigma plugboard.
// Holds the default alphabet and cable-count sizes, the configuration
// state enum, the swap-table entry layout and the one-hot <-> binary index
// helpers used wherever a letter crosses into or out of the table domain.
package plug_pkg;

    localparam int PLUG_LETTERS   = 26;
    localparam int PLUG_MAX_PAIRS = 10;
    localparam int PLUG_IDX_W     = 5;
    localparam int PLUG_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF  = 2'd1,
        CLEAR = 2'd2
    } cfg_state_t;

    // One cable: letters a and b are swapped while valid is set.
    typedef struct packed {
        logic                  valid;
        logic [PLUG_IDX_W-1:0] a;
        logic [PLUG_IDX_W-1:0] b;
    } pair_entry_t;

    // Result of converting a one-hot letter into a binary index.
    typedef struct packed {
        logic                  is_onehot;
        logic [PLUG_IDX_W-1:0] idx;
    } letter_idx_t;

    // Binary index of the set bit; is_onehot is clear for zero or multi-hot
    // inputs, in which case idx carries no meaning.
    function automatic letter_idx_t onehot_to_idx(input logic [PLUG_LETTERS-1:0] v);
        letter_idx_t r;
        int          ones;
        r.idx = '0;
        ones  = 0;
        for (int i = 0; i < PLUG_LETTERS; i++) begin
            if (v[i]) begin
                r.idx = PLUG_IDX_W'(i);
                ones  = ones + 1;
            end
        end
        r.is_onehot = (ones == 1);
        return r;
    endfunction

    // Comparing against each position avoids an out-of-range write for
    // index codes beyond the alphabet.
    function automatic logic [PLUG_LETTERS-1:0] idx_to_onehot(input logic [PLUG_IDX_W-1:0] idx);
        logic [PLUG_LETTERS-1:0] v;
        for (int i = 0; i < PLUG_LETTERS; i++) begin
            v[i] = (idx == PLUG_IDX_W'(i));
        end
        return v;
    endfunction

endpackage

// File: rtl/plug_lookup.sv
// plug_lookup
// Combinational match of one letter index against the whole swap table.
// Ports:
//   entries  in   swap table, one pair_entry_t per cable
//   idx      in   binary letter index to look up
//   hit      out  idx is one end of a valid cable
//   partner  out  other end of that cable, or idx itself when there is no hit
module plug_lookup
    import plug_pkg::*;
#(
    parameter int MAX_PAIRS = PLUG_MAX_PAIRS,
    parameter int IDX_W     = PLUG_IDX_W
) (
    input  pair_entry_t [MAX_PAIRS-1:0] entries,
    input  logic        [IDX_W-1:0]     idx,
    output logic                        hit,
    output logic        [IDX_W-1:0]     partner
);

    // At most one valid entry can contain a given letter, so the scan order
    // does not matter for the result.
    always_comb begin
        hit     = 1'b0;
        partner = idx;
        for (int i = 0; i < MAX_PAIRS; i++) begin
            if (entries[i].valid && (entries[i].a == idx)) begin
                hit     = 1'b1;
                partner = entries[i].b;
            end else if (entries[i].valid && (entries[i].b == idx)) begin
                hit     = 1'b1;
                partner = entries[i].a;
            end
        end
    end

endmodule

// File: rtl/plugboard_prog.sv
// plugboard_prog
// Runtime-programmable Enigma plugboard holding up to MAX_PAIRS letter swaps.
// The forward channel feeds the rotors, the reverse channel feeds the display.
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   synchronous active-high reset
//   cfg_valid     in   configuration letter strobe, one cycle per letter
//   cfg_letter    in   one-hot letter being plugged or unplugged
//   cfg_clear     in   pulse: remove all pairs
//   cfg_ready     out  cfg_valid / cfg_clear will be accepted
//   cfg_error     out  one-cycle pulse when a configuration letter is rejected
//   pair_count    out  number of valid pairs
//   half_pending  out  first letter of a pair is held
//   in_valid      in   lookup strobe for both channels
//   fwd_in        in   keyboard letter
//   rev_in        in   letter returning from the rotors
//   out_valid     out  in_valid delayed one cycle
//   fwd_out       out  plugged forward letter
//   rev_out       out  plugged reverse letter
module plugboard_prog
    import plug_pkg::*;
#(
    parameter int LETTERS   = PLUG_LETTERS,
    parameter int MAX_PAIRS = PLUG_MAX_PAIRS,
    parameter int IDX_W     = PLUG_IDX_W,
    parameter int CNT_W     = PLUG_CNT_W
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [LETTERS-1:0] cfg_letter,
    input  logic               cfg_clear,
    output logic               cfg_ready,
    output logic               cfg_error,
    output logic [CNT_W-1:0]   pair_count,
    output logic               half_pending,
    input  logic               in_valid,
    input  logic [LETTERS-1:0] fwd_in,
    input  logic [LETTERS-1:0] rev_in,
    output logic               out_valid,
    output logic [LETTERS-1:0] fwd_out,
    output logic [LETTERS-1:0] rev_out
);

    localparam int SLOT_W = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;

    pair_entry_t [MAX_PAIRS-1:0] entries;
    cfg_state_t                  state;
    cfg_state_t                  next_state;
    logic        [IDX_W-1:0]     held_idx;
    logic        [SLOT_W-1:0]    clr_idx;

    letter_idx_t                 fwd_li;
    letter_idx_t                 rev_li;
    letter_idx_t                 cfg_li;
    logic                        fwd_hit;
    logic                        rev_hit;
    logic                        cfg_hit;
    logic        [IDX_W-1:0]     fwd_partner;
    logic        [IDX_W-1:0]     rev_partner;
    logic        [IDX_W-1:0]     cfg_partner;
    logic        [LETTERS-1:0]   fwd_next;
    logic        [LETTERS-1:0]   rev_next;

    logic                        table_full;
    logic        [MAX_PAIRS-1:0] free_mask;
    logic        [MAX_PAIRS-1:0] unplug_mask;

    logic                        do_latch;
    logic                        do_unplug;
    logic                        do_commit;
    logic                        do_reject;
    logic                        do_enter_clear;
    logic                        do_clear_step;

    // ------------------------------------------------------------------
    // Boundary conversion and the three table matchers
    // ------------------------------------------------------------------
    assign fwd_li = onehot_to_idx(fwd_in);
    assign rev_li = onehot_to_idx(rev_in);
    assign cfg_li = onehot_to_idx(cfg_letter);

    plug_lookup #(.MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_fwd_lookup (
        .entries (entries),
        .idx     (fwd_li.idx),
        .hit     (fwd_hit),
        .partner (fwd_partner)
    );

    plug_lookup #(.MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_rev_lookup (
        .entries (entries),
        .idx     (rev_li.idx),
        .hit     (rev_hit),
        .partner (rev_partner)
    );

    plug_lookup #(.MAX_PAIRS(MAX_PAIRS), .IDX_W(IDX_W)) u_cfg_lookup (
        .entries (entries),
        .idx     (cfg_li.idx),
        .hit     (cfg_hit),
        .partner (cfg_partner)
    );

    // Malformed letters go out as all-zero so downstream one-hot logic
    // never sees a multi-hot vector.
    always_comb begin
        fwd_next = '0;
        rev_next = '0;
        if (fwd_li.is_onehot) begin
            fwd_next = fwd_hit ? idx_to_onehot(fwd_partner) : fwd_in;
        end
        if (rev_li.is_onehot) begin
            rev_next = rev_hit ? idx_to_onehot(rev_partner) : rev_in;
        end
    end

    // Registered lookup; the table used is the one before any same-cycle
    // configuration write, and configuration state never stalls it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_valid <= 1'b0;
            fwd_out   <= '0;
            rev_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                fwd_out <= fwd_next;
                rev_out <= rev_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table occupancy helpers
    // ------------------------------------------------------------------
    always_comb begin
        pair_count = '0;
        for (int i = 0; i < MAX_PAIRS; i++) begin
            pair_count = pair_count + CNT_W'(entries[i].valid);
        end
    end

    assign table_full = (pair_count == CNT_W'(MAX_PAIRS));

    // Lowest-index invalid entry receives a newly committed cable.
    always_comb begin
        logic found;
        free_mask = '0;
        found     = 1'b0;
        for (int i = 0; i < MAX_PAIRS; i++) begin
            if (!found && !entries[i].valid) begin
                free_mask[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // The cable to unplug is identified by both of its ends.
    always_comb begin
        unplug_mask = '0;
        for (int i = 0; i < MAX_PAIRS; i++) begin
            unplug_mask[i] = entries[i].valid &&
                             (((entries[i].a == cfg_li.idx) && (entries[i].b == cfg_partner)) ||
                              ((entries[i].b == cfg_li.idx) && (entries[i].a == cfg_partner)));
        end
    end

    // ------------------------------------------------------------------
    // Configuration FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Configuration FSM: next state
    // cfg_clear wins over a simultaneous cfg_valid; CLEAR ignores both.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cfg_clear) begin
                    next_state = CLEAR;
                end else if (cfg_valid && cfg_li.is_onehot && !cfg_hit && !table_full) begin
                    next_state = HALF;
                end
            end
            HALF: begin
                if (cfg_clear) begin
                    next_state = CLEAR;
                end else if (cfg_valid) begin
                    next_state = IDLE;
                end
            end
            CLEAR: begin
                if (clr_idx == SLOT_W'(MAX_PAIRS - 1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration FSM: outputs and table actions
    // In HALF, repeating the held letter cancels silently; it cannot also
    // be plugged because the table only changes through this FSM.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready      = (state != CLEAR);
        half_pending   = (state == HALF);
        do_latch       = 1'b0;
        do_unplug      = 1'b0;
        do_commit      = 1'b0;
        do_reject      = 1'b0;
        do_enter_clear = 1'b0;
        do_clear_step  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_clear) begin
                    do_enter_clear = 1'b1;
                end else if (cfg_valid) begin
                    if (!cfg_li.is_onehot) begin
                        do_reject = 1'b1;
                    end else if (cfg_hit) begin
                        do_unplug = 1'b1;
                    end else if (table_full) begin
                        do_reject = 1'b1;
                    end else begin
                        do_latch = 1'b1;
                    end
                end
            end
            HALF: begin
                if (cfg_clear) begin
                    do_enter_clear = 1'b1;
                end else if (cfg_valid) begin
                    if (!cfg_li.is_onehot) begin
                        do_reject = 1'b1;
                    end else if (cfg_li.idx == held_idx) begin
                        do_reject = 1'b0;
                    end else if (cfg_hit) begin
                        do_reject = 1'b1;
                    end else begin
                        do_commit = 1'b1;
                    end
                end
            end
            CLEAR: begin
                do_clear_step = 1'b1;
            end
            default: begin
                do_reject = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration datapath: held letter, clear sweep and table writes
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            entries   <= '0;
            held_idx  <= '0;
            clr_idx   <= '0;
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= do_reject;
            if (do_latch) begin
                held_idx <= cfg_li.idx;
            end
            if (do_enter_clear) begin
                clr_idx <= '0;
            end else if (do_clear_step) begin
                clr_idx <= clr_idx + SLOT_W'(1);
            end
            for (int i = 0; i < MAX_PAIRS; i++) begin
                if (do_unplug && unplug_mask[i]) begin
                    entries[i].valid <= 1'b0;
                end
                if (do_commit && free_mask[i]) begin
                    entries[i] <= '{valid: 1'b1, a: held_idx, b: cfg_li.idx};
                end
                if (do_clear_step && (clr_idx == SLOT_W'(i))) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule
